// File: rtl/enigma_pkg.sv
// Shared constants, FSM state type and rotor-position helpers for the Enigma rotor bank.
package enigma_pkg;

   localparam int unsigned ALPHABET  = 26;
   localparam int unsigned POS_W     = 5;

   // Default turnover notches of the historical rotors I, II and III
   localparam int unsigned NOTCH_I   = 16;
   localparam int unsigned NOTCH_II  = 4;
   localparam int unsigned NOTCH_III = 21;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_STEP    = 2'd1,
      S_HOLD    = 2'd2,
      S_RELEASE = 2'd3
   } state_e;

   // Fold an out-of-range 5-bit value back into 0..25
   function automatic logic [POS_W-1:0] pos_reduce(input logic [POS_W-1:0] p);
      return (p >= POS_W'(ALPHABET)) ? p - POS_W'(ALPHABET) : p;
   endfunction

   // Advance one position, wrapping 25 -> 0
   function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
      return (p == POS_W'(ALPHABET - 1)) ? '0 : p + POS_W'(1);
   endfunction

endpackage

// File: rtl/enigma_rotor_stepper_if.sv
// Position-set handoff from the rotor stepper to the cipher path.
//   step_valid : a new position set is presented
//   step_ready : cipher path accepts the position set
//   pos_l/m/r  : shadow rotor positions, 0..25
interface enigma_rotor_stepper_if;
   import enigma_pkg::*;

   logic             step_valid;
   logic             step_ready;
   logic [POS_W-1:0] pos_l;
   logic [POS_W-1:0] pos_m;
   logic [POS_W-1:0] pos_r;

   modport master (output step_valid, pos_l, pos_m, pos_r, input step_ready);
   modport slave  (input step_valid, pos_l, pos_m, pos_r, output step_ready);

endinterface

// File: rtl/key_debouncer.sv
// Synchronises and debounces an active-low key and flags each accepted press.
//   clk, rst_n : clock, async active-low reset
//   key_n_i    : raw key, active-low, asynchronous
//   level_o    : debounced level (1 = released)
//   press_o    : one-cycle pulse on an accepted 1->0 debounced transition
// DEBOUNCE_CYCLES must be at least 3: the synchroniser powers up reading
// "pressed" for two samples, which must not be mistaken for a real press.
module key_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n_i,
   output logic level_o,
   output logic press_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic             level_q;
   logic             armed_q;
   logic             press_q;

   // The synchroniser resets to "pressed" so a key already held through reset
   // never arms the press detector; the first released sample arms it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b1;
         armed_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
         press_q <= 1'b0;
         if (sync2_q) begin
            armed_q <= 1'b1;
         end
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
            press_q <= ~sync2_q & armed_q;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/enigma_rotor_stepper.sv
// Enigma rotor stepping controller: one odometer step per debounced keystroke,
// with notch carry and middle-rotor double step, and a valid/ready handoff of
// the new shadow positions to the cipher path.
//   CLOCK_50, resetn        : clock, async active-low reset
//   key_n                   : raw active-low key
//   load, init_l/m/r        : load initial positions (IDLE only)
//   step_l/m/r              : one-cycle increment pulses to the rotors
//   busy                    : high outside IDLE
//   cp                      : step_valid/step_ready + pos_l/m/r handoff
module enigma_rotor_stepper
   import enigma_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned NOTCH_R         = NOTCH_III,
   parameter int unsigned NOTCH_M         = NOTCH_II
) (
   input  logic                   CLOCK_50,
   input  logic                   resetn,
   input  logic                   key_n,
   input  logic                   load,
   input  logic [POS_W-1:0]       init_l,
   input  logic [POS_W-1:0]       init_m,
   input  logic [POS_W-1:0]       init_r,
   output logic                   step_l,
   output logic                   step_m,
   output logic                   step_r,
   output logic                   busy,
   enigma_rotor_stepper_if.master cp
);

   logic             key_level;
   logic             key_press;

   state_e           state_q;
   logic [POS_W-1:0] pos_l_q;
   logic [POS_W-1:0] pos_m_q;
   logic [POS_W-1:0] pos_r_q;
   logic             step_l_q;
   logic             step_m_q;
   logic             step_r_q;
   logic             valid_q;
   logic             busy_q;

   logic             carry_m_c;
   logic             carry_l_c;

   key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key_debouncer (
      .clk     (CLOCK_50),
      .rst_n   (resetn),
      .key_n_i (key_n),
      .level_o (key_level),
      .press_o (key_press)
   );

   // Odometer rule on the pre-step positions; the middle-notch term is the double step
   assign carry_m_c = (pos_r_q == POS_W'(NOTCH_R)) | (pos_m_q == POS_W'(NOTCH_M));
   assign carry_l_c = (pos_m_q == POS_W'(NOTCH_M));

   // Keystroke FSM; pulses are launched on entry to STEP so they are high only there
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         pos_l_q  <= '0;
         pos_m_q  <= '0;
         pos_r_q  <= '0;
         step_l_q <= 1'b0;
         step_m_q <= 1'b0;
         step_r_q <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         step_l_q <= 1'b0;
         step_m_q <= 1'b0;
         step_r_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // load takes priority; a coincident press is discarded
               if (load) begin
                  pos_l_q <= pos_reduce(init_l);
                  pos_m_q <= pos_reduce(init_m);
                  pos_r_q <= pos_reduce(init_r);
               end else if (key_press) begin
                  state_q  <= S_STEP;
                  busy_q   <= 1'b1;
                  step_r_q <= 1'b1;
                  step_m_q <= carry_m_c;
                  step_l_q <= carry_l_c;
               end
            end
            S_STEP: begin
               pos_r_q <= pos_inc(pos_r_q);
               if (step_m_q) begin
                  pos_m_q <= pos_inc(pos_m_q);
               end
               if (step_l_q) begin
                  pos_l_q <= pos_inc(pos_l_q);
               end
               state_q <= S_HOLD;
               valid_q <= 1'b1;
            end
            S_HOLD: begin
               if (cp.step_ready) begin
                  state_q <= S_RELEASE;
                  valid_q <= 1'b0;
               end
            end
            S_RELEASE: begin
               if (key_level) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign step_l        = step_l_q;
   assign step_m        = step_m_q;
   assign step_r        = step_r_q;
   assign busy          = busy_q;
   assign cp.step_valid = valid_q;
   assign cp.pos_l      = pos_l_q;
   assign cp.pos_m      = pos_m_q;
   assign cp.pos_r      = pos_r_q;

endmodule
